irrigation_sequencer: RTL and testbench



---
 rtl/irrigation_sequencer.sv | 150 +++++++++++++++
 tb/tb_irrigation_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// Soak-cycle sequencer for the valve flow level: ramps up on dry soil, holds at full flow,
// ramps down on wet soil, hold expiry or operator stop, and drops to FAULT when the tank is empty.
module irrigation_sequencer #(
  parameter int unsigned MAX_LEVEL  = 7,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       dry,
  input  logic       wet,
  input  logic       tank_ok,
  input  logic       manual_stop,
  output logic [2:0] level,
  output logic       valve_open,
  output logic [2:0] state,
  output logic       alarm
);

  localparam int unsigned LW = 3;
  localparam int unsigned SW = 3;
  localparam int unsigned HW = 4;
  localparam logic [LW-1:0] LMAX  = LW'(MAX_LEVEL);
  localparam logic [HW-1:0] HMAX  = HW'(HOLD_TICKS);
  localparam logic [LW-1:0] LONE  = LW'(1);

  typedef enum logic [SW-1:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD      = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t          cur_state, nxt_state;
  logic [LW-1:0]   level_q, level_d, level_inc, level_dec;
  logic [HW-1:0]   hold_q, hold_d, hold_inc;
  logic            valve_q, valve_d;
  logic            alarm_q, alarm_d;
  logic            start_ok;

  // Saturating step values; level never wraps and the hold count sticks at all-ones.
  always_comb begin
    level_inc = (level_q >= LMAX) ? LMAX : level_q + LONE;
    level_dec = (level_q == '0) ? '0 : level_q - LONE;
    hold_inc  = (hold_q == '1) ? hold_q : hold_q + HW'(1);
    start_ok  = tick && dry && !wet && tank_ok && !manual_stop;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= S_IDLE;
      level_q   <= '0;
      hold_q    <= '0;
      valve_q   <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      level_q   <= level_d;
      hold_q    <= hold_d;
      valve_q   <= valve_d;
      alarm_q   <= alarm_d;
    end
  end

  // Next-state logic; tank fault outranks manual stop, which outranks the sensors.
  always_comb begin
    nxt_state = cur_state;
    level_d   = level_q;
    hold_d    = hold_q;
    case (cur_state)
      S_IDLE: begin
        level_d = '0;
        if (start_ok) begin
          level_d   = LONE;
          hold_d    = '0;
          nxt_state = (LONE >= LMAX) ? S_HOLD : S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (!tank_ok) begin
          nxt_state = S_FAULT;
          level_d   = '0;
        end else if (manual_stop) begin
          nxt_state = S_RAMP_DOWN;
        end else if (tick) begin
          if (wet) begin
            nxt_state = S_RAMP_DOWN;
          end else begin
            level_d = level_inc;
            if (level_inc == LMAX) begin
              nxt_state = S_HOLD;
              hold_d    = '0;
            end
          end
        end
      end
      S_HOLD: begin
        if (!tank_ok) begin
          nxt_state = S_FAULT;
          level_d   = '0;
        end else if (manual_stop) begin
          nxt_state = S_RAMP_DOWN;
        end else if (tick) begin
          hold_d = hold_inc;
          if (wet || (hold_inc >= HMAX)) begin
            nxt_state = S_RAMP_DOWN;
          end
        end
      end
      S_RAMP_DOWN: begin
        if (!tank_ok) begin
          nxt_state = S_FAULT;
          level_d   = '0;
        end else if (tick) begin
          level_d = level_dec;
          if (level_dec == '0) begin
            nxt_state = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        level_d = '0;
        if (tick && tank_ok && !manual_stop) begin
          nxt_state = S_IDLE;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        level_d   = '0;
        hold_d    = '0;
      end
    endcase
  end

  // Output decode from next state/level so valve_open and alarm are registered alongside them.
  always_comb begin
    valve_d = 1'b0;
    alarm_d = 1'b0;
    if (level_d != '0) valve_d = 1'b1;
    if (nxt_state == S_FAULT) alarm_d = 1'b1;
  end

  assign level      = level_q;
  assign valve_open = valve_q;
  assign state      = cur_state;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer: a default instance (7/4) and a small instance (3/1) share
// stimulus; whichever is not under test is held in reset and checked as idle.
module tb_irrigation_sequencer;

  localparam logic [2:0] I  = 3'd0;
  localparam logic [2:0] RU = 3'd1;
  localparam logic [2:0] H  = 3'd2;
  localparam logic [2:0] RD = 3'd3;
  localparam logic [2:0] F  = 3'd4;

  logic       clock = 1'b0;
  logic       reset_a = 1'b1, reset_b = 1'b1;
  logic       tick = 1'b0, dry = 1'b0, wet = 1'b0, tank_ok = 1'b1, manual_stop = 1'b0;
  logic [2:0] level_a, state_a, level_b, state_b;
  logic       valve_a, alarm_a, valve_b, alarm_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] sa;
    logic [2:0] la;
    logic [2:0] sb;
    logic [2:0] lb;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  irrigation_sequencer #(.MAX_LEVEL(7), .HOLD_TICKS(4)) dut_a (
    .clock(clock), .reset(reset_a), .tick(tick), .dry(dry), .wet(wet),
    .tank_ok(tank_ok), .manual_stop(manual_stop),
    .level(level_a), .valve_open(valve_a), .state(state_a), .alarm(alarm_a)
  );

  irrigation_sequencer #(.MAX_LEVEL(3), .HOLD_TICKS(1)) dut_b (
    .clock(clock), .reset(reset_b), .tick(tick), .dry(dry), .wet(wet),
    .tank_ok(tank_ok), .manual_stop(manual_stop),
    .level(level_b), .valve_open(valve_b), .state(state_b), .alarm(alarm_b)
  );

  // Monitor: after every edge, pop the expectation for that edge and compare both instances.
  always @(posedge clock) begin
    exp_t e;
    logic [7:0] act_v, req_v;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_v = {state_a, level_a, valve_a, alarm_a};
      req_v = {e.sa, e.la, (e.la != 3'd0), (e.sa == F)};
      total++;
      if (act_v !== req_v) begin
        bad++;
        $display("FAIL dut_a step %0d: got state=%0d level=%0d valve=%0d alarm=%0d, want state=%0d level=%0d valve=%0d alarm=%0d",
                 total, act_v[7:5], act_v[4:2], act_v[1], act_v[0], req_v[7:5], req_v[4:2], req_v[1], req_v[0]);
      end
      act_v = {state_b, level_b, valve_b, alarm_b};
      req_v = {e.sb, e.lb, (e.lb != 3'd0), (e.sb == F)};
      total++;
      if (act_v !== req_v) begin
        bad++;
        $display("FAIL dut_b step %0d: got state=%0d level=%0d valve=%0d alarm=%0d, want state=%0d level=%0d valve=%0d alarm=%0d",
                 total, act_v[7:5], act_v[4:2], act_v[1], act_v[0], req_v[7:5], req_v[4:2], req_v[1], req_v[0]);
      end
    end
  end

  // Drive one cycle of inputs and queue what both instances must show after the edge.
  task automatic step(input logic ra, input logic rb, input logic tk, input logic dr,
                      input logic wt, input logic ok, input logic st,
                      input logic [2:0] sa, input logic [2:0] la,
                      input logic [2:0] sb, input logic [2:0] lb);
    exp_t e;
    @(negedge clock);
    reset_a = ra; reset_b = rb;
    tick = tk; dry = dr; wet = wt; tank_ok = ok; manual_stop = st;
    e.sa = sa; e.la = la; e.sb = sb; e.lb = lb;
    exp_q.push_back(e);
  endtask

  // Phase A shorthand: instance b held in reset, expected idle.
  task automatic sa_(input logic tk, input logic dr, input logic wt, input logic ok,
                     input logic st, input logic [2:0] s, input logic [2:0] l);
    step(1'b0, 1'b1, tk, dr, wt, ok, st, s, l, I, 3'd0);
  endtask

  // Phase B shorthand: instance a held in reset, expected idle.
  task automatic sb_(input logic rb, input logic tk, input logic dr, input logic wt,
                     input logic ok, input logic st, input logic [2:0] s, input logic [2:0] l);
    step(1'b1, rb, tk, dr, wt, ok, st, I, 3'd0, s, l);
  endtask

  initial begin
    // Reset with inputs that would otherwise start a ramp.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, I, 3'd0, I, 3'd0);

    // Full cycle: ramp 1..7, hold 4 ticks, ramp down to idle.
    sa_(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, I, 3'd0);
    for (int i = 1; i <= 6; i++) sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RU, 3'(i));
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, H, 3'd7);
    sa_(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, H, 3'd7);
    for (int i = 1; i <= 3; i++) sa_(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, H, 3'd7);
    sa_(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RD, 3'd7);
    for (int i = 6; i >= 1; i--) sa_(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RD, 3'(i));
    sa_(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I, 3'd0);

    // Wet during ramp up: down without increment, then back to idle.
    for (int i = 1; i <= 3; i++) sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RU, 3'(i));
    sa_(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, RD, 3'd3);
    sa_(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, RD, 3'd2);
    sa_(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, RD, 3'd1);
    sa_(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, I, 3'd0);

    // Tank empties in HOLD without a tick, then FAULT exit rules.
    for (int i = 1; i <= 6; i++) sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RU, 3'(i));
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, H, 3'd7);
    sa_(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F, 3'd0);
    sa_(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, F, 3'd0);
    sa_(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F, 3'd0);
    sa_(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, I, 3'd0);

    // Sensor conflict in idle never starts a ramp.
    for (int i = 0; i < 5; i++) sa_(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, I, 3'd0);

    // Manual stop mid-ramp without a tick; held stop blocks restart from idle.
    for (int i = 1; i <= 5; i++) sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RU, 3'(i));
    sa_(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, RD, 3'd5);
    for (int i = 4; i >= 1; i--) sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, RD, 3'(i));
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, I, 3'd0);
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, I, 3'd0);
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, I, 3'd0);
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RU, 3'd1);

    // Tank fault from RAMP_UP; FAULT needs a tick and no stop to leave; empty tank blocks a start.
    sa_(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, F, 3'd0);
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F, 3'd0);
    sa_(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, I, 3'd0);
    sa_(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, I, 3'd0);

    // Small instance: MAX_LEVEL=3, HOLD_TICKS=1; reset lands mid ramp-down.
    sb_(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, I, 3'd0);
    sb_(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RU, 3'd1);
    sb_(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RU, 3'd2);
    sb_(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, H, 3'd3);
    sb_(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RD, 3'd3);
    sb_(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RD, 3'd2);
    sb_(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, I, 3'd0);
    sb_(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, I, 3'd0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
